cu_buff_reader: RTL and testbench

Downstream consumer of the ADC ping-pong buffer control unit. On each write_done pulse it reads the just-completed 256-word half of the 512x16 dual-port sample RAM. It streams that half to the UART transmitter as a header byte followed by two bytes per word, MSB first. It queues one pending half and flags overruns when the host link cannot keep up.

---
 rtl/cu_pkg.sv | 25 ++
 rtl/tx_byte_hs.sv | 44 ++++
 rtl/cu_buff_reader.sv | 180 ++++++++++++++++++
 tb/tb_cu_buff_reader.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared definitions for the ping-pong buffer reader: RAM geometry, sync byte and
// the reader FSM state encoding.
package cu_pkg;

    localparam int unsigned HALF_DEPTH = 256;
    localparam int unsigned OFF_W      = $clog2(HALF_DEPTH);
    localparam int unsigned ADDR_W     = OFF_W + 1;
    localparam int unsigned DATA_W     = 16;
    localparam logic [7:0]  HDR_BYTE   = 8'hA5;

    typedef enum logic [3:0] {
        StIdle   = 4'd0,
        StHdr    = 4'd1,
        StWaitH  = 4'd2,
        StRd     = 4'd3,
        StRdW    = 4'd4,
        StSndHi  = 4'd5,
        StWaitHi = 4'd6,
        StSndLo  = 4'd7,
        StWaitLo = 4'd8,
        StNext   = 4'd9,
        StDone   = 4'd10
    } state_e;

endpackage

// File: rtl/tx_byte_hs.sv
// One-byte UART handshake: issues tx_start when the UART is free, holds the byte,
// and reports completion once tx_busy has been seen high and then low again.
module tx_byte_hs (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_send,
    input  logic [7:0] i_data,
    input  logic       i_tx_busy,
    output logic [7:0] o_tx_data,
    output logic       o_tx_start,
    output logic       o_byte_done
);

    logic [7:0] r_data;
    logic       r_pending;
    logic       r_saw_busy;
    logic       w_start;

    // A request stalls while the UART is still busy with an earlier byte.
    assign w_start = i_send & ~i_tx_busy & ~r_pending;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_data     <= 8'h00;
            r_pending  <= 1'b0;
            r_saw_busy <= 1'b0;
        end else if (w_start) begin
            r_data     <= i_data;
            r_pending  <= 1'b1;
            r_saw_busy <= 1'b0;
        end else if (r_pending) begin
            if (i_tx_busy) begin
                r_saw_busy <= 1'b1;
            end else if (r_saw_busy) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign o_tx_start  = w_start;
    assign o_tx_data   = w_start ? i_data : r_data;
    assign o_byte_done = r_pending & r_saw_busy & ~i_tx_busy;

endmodule

// File: rtl/cu_buff_reader.sv
// Streams each completed half of the ping-pong sample RAM to the UART as a sync
// byte followed by every word MSB first; one further request can be queued.
module cu_buff_reader #(
    parameter int unsigned ADDR_W   = cu_pkg::ADDR_W,
    parameter int unsigned DATA_W   = cu_pkg::DATA_W,
    parameter logic [7:0]  HDR_BYTE = cu_pkg::HDR_BYTE
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_write_done,
    input  logic              i_wr_half,
    input  logic [DATA_W-1:0] i_rd_data,
    input  logic              i_tx_busy,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_start,
    output logic              o_busy,
    output logic              o_overrun,
    output logic              o_half_sent
);

    import cu_pkg::*;

    localparam int unsigned OFF_BITS = ADDR_W - 1;

    state_e              r_state;
    logic                r_q_valid;
    logic                r_q_half;
    logic                r_overrun;
    logic                r_half;
    logic [OFF_BITS-1:0] r_offset;
    logic [DATA_W-1:0]   r_word;
    logic                r_rd_en;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic                r_busy;
    logic                r_half_sent;

    logic                w_consume;
    logic                w_send;
    logic [7:0]          w_byte;
    logic                w_tx_start;
    logic                w_byte_done;
    logic [OFF_BITS-1:0] w_off_next;

    assign w_consume  = (r_state == StIdle) && r_q_valid;
    assign w_off_next = r_offset + {{(OFF_BITS-1){1'b0}}, 1'b1};

    // A request arriving while one is already waiting is dropped; the older one wins.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_q_valid <= 1'b0;
            r_q_half  <= 1'b0;
            r_overrun <= 1'b0;
        end else if (i_write_done) begin
            if (r_q_valid && !w_consume) begin
                r_overrun <= 1'b1;
            end else begin
                r_q_valid <= 1'b1;
                r_q_half  <= ~i_wr_half;
            end
        end else if (w_consume) begin
            r_q_valid <= 1'b0;
        end
    end

    always_comb begin
        w_send = 1'b0;
        w_byte = r_word[7:0];
        case (r_state)
            StHdr: begin
                w_send = 1'b1;
                w_byte = HDR_BYTE;
            end
            StSndHi: begin
                w_send = 1'b1;
                w_byte = r_word[DATA_W-1 -: 8];
            end
            StSndLo: begin
                w_send = 1'b1;
                w_byte = r_word[7:0];
            end
            default: ;
        endcase
    end

    tx_byte_hs u_tx_byte_hs (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_send      (w_send),
        .i_data      (w_byte),
        .i_tx_busy   (i_tx_busy),
        .o_tx_data   (o_tx_data),
        .o_tx_start  (w_tx_start),
        .o_byte_done (w_byte_done)
    );

    // Outputs are set on the transition into the state they belong to.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state     <= StIdle;
            r_half      <= 1'b0;
            r_offset    <= '0;
            r_word      <= '0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_busy      <= 1'b0;
            r_half_sent <= 1'b0;
        end else begin
            r_rd_en     <= 1'b0;
            r_half_sent <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (r_q_valid) begin
                        r_half   <= r_q_half;
                        r_offset <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= StHdr;
                    end
                end
                StHdr: begin
                    if (w_tx_start) r_state <= StWaitH;
                end
                StWaitH: begin
                    if (w_byte_done) begin
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= {r_half, r_offset};
                        r_state   <= StRd;
                    end
                end
                StRd: begin
                    r_state <= StRdW;
                end
                StRdW: begin
                    r_word  <= i_rd_data;
                    r_state <= StSndHi;
                end
                StSndHi: begin
                    if (w_tx_start) r_state <= StWaitHi;
                end
                StWaitHi: begin
                    if (w_byte_done) r_state <= StSndLo;
                end
                StSndLo: begin
                    if (w_tx_start) r_state <= StWaitLo;
                end
                StWaitLo: begin
                    if (w_byte_done) r_state <= StNext;
                end
                StNext: begin
                    if (r_offset == '1) begin
                        r_half_sent <= 1'b1;
                        r_state     <= StDone;
                    end else begin
                        r_offset  <= w_off_next;
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= {r_half, w_off_next};
                        r_state   <= StRd;
                    end
                end
                StDone: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_rd_en     = r_rd_en;
    assign o_rd_addr   = r_rd_addr;
    assign o_tx_start  = w_tx_start;
    assign o_busy      = r_busy;
    assign o_overrun   = r_overrun;
    assign o_half_sent = r_half_sent;

endmodule

// File: tb/tb_cu_buff_reader.sv
// Bench for cu_buff_reader: RAM and UART models, randomized busy lengths and RAM
// contents, and a byte-stream reference built directly from the RAM image.
module tb_cu_buff_reader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        write_done;
    logic        wr_half;
    logic [15:0] rd_data;
    logic        tx_busy;
    logic        rd_en;
    logic [8:0]  rd_addr;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        busy;
    logic        overrun;
    logic        half_sent;

    int checks   = 0;
    int failures = 0;

    logic [15:0] mem [512];
    logic [7:0]  rx_q[$];
    logic [8:0]  addr_q[$];
    int          start_q[$];
    int          hs_q[$];
    int          wd_q[$];
    int          cyc = 0;
    int          uart_cnt = 0;
    int          n_bad_start = 0;
    int          busy_min = 10;
    int          busy_max = 10;
    logic        force_busy = 1'b0;

    always #5 clk = ~clk;

    assign tx_busy = (uart_cnt != 0) || force_busy;

    cu_buff_reader dut (
        .i_clk        (clk),
        .i_reset      (reset_n),
        .i_write_done (write_done),
        .i_wr_half    (wr_half),
        .i_rd_data    (rd_data),
        .i_tx_busy    (tx_busy),
        .o_rd_en      (rd_en),
        .o_rd_addr    (rd_addr),
        .o_tx_data    (tx_data),
        .o_tx_start   (tx_start),
        .o_busy       (busy),
        .o_overrun    (overrun),
        .o_half_sent  (half_sent)
    );

    // Synchronous-read RAM and a UART that stays busy for a random number of cycles.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (write_done) wd_q.push_back(cyc);
        if (rd_en) addr_q.push_back(rd_addr);
        if (half_sent) hs_q.push_back(cyc);
        if (tx_start) begin
            rx_q.push_back(tx_data);
            start_q.push_back(cyc);
            if (tx_busy) n_bad_start <= n_bad_start + 1;
            uart_cnt <= int'($urandom_range(busy_max, busy_min));
        end else if (uart_cnt != 0) begin
            uart_cnt <= uart_cnt - 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int half, input int k);
        logic [15:0] w;
        if (k == 0) return 8'hA5;
        w = mem[half * 256 + (k - 1) / 2];
        return ((k - 1) % 2 == 0) ? w[15:8] : w[7:0];
    endfunction

    task automatic check_half(input string tag, input int rb, input int ab, input int half);
        int nbad  = 0;
        int nabad = 0;
        for (int k = 0; k < 513; k++) begin
            if (rb + k >= rx_q.size()) nbad++;
            else if (rx_q[rb + k] !== exp_byte(half, k)) nbad++;
        end
        for (int i = 0; i < 256; i++) begin
            if (ab + i >= addr_q.size()) nabad++;
            else if (addr_q[ab + i] !== 9'(half * 256 + i)) nabad++;
        end
        chk({tag, "_bytes"}, nbad, 0);
        chk({tag, "_addrs"}, nabad, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic pulse_wd(input logic h);
        @(negedge clk);
        wr_half    = h;
        write_done = 1'b1;
        @(negedge clk);
        write_done = 1'b0;
    endtask

    task automatic wait_hs(input string tag, input int target, input int budget);
        int k = 0;
        while (hs_q.size() < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_done_in_time"}, 32'(hs_q.size() >= target), 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_tx_data"}, tx_data, 0);
        chk({tag, "_tx_start"}, tx_start, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_overrun"}, overrun, 0);
        chk({tag, "_half_sent"}, half_sent, 0);
    endtask

    initial begin
        int rb, ab, sb, hb, wb, nz, k;
        reset_n    = 1'b0;
        write_done = 1'b0;
        wr_half    = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem[i]       = 16'h1000 + 16'(i);
            mem[256 + i] = 16'hB000 + 16'(i);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Reset state and a quiet idle period
        check_outputs_zero("reset");
        nz = 0;
        repeat (100) begin
            @(negedge clk);
            if (rd_en || rd_addr != 0 || tx_data != 0 || tx_start || busy || overrun || half_sent)
                nz++;
        end
        chk("idle_quiet", nz, 0);

        // Lower half, 10-cycle UART
        rb = rx_q.size(); ab = addr_q.size(); sb = start_q.size(); hb = hs_q.size();
        wb = wd_q.size();
        pulse_wd(1'b1);
        @(negedge clk);
        chk("s1_busy", busy, 1);
        wait_hs("s1", hb + 1, 20000);
        repeat (30) @(negedge clk);
        check_half("s1", rb, ab, 0);
        chk("s1_nbytes", rx_q.size() - rb, 513);
        chk("s1_latency", (start_q.size() > sb) ? start_q[sb] - wd_q[wb] : -1, 2);
        chk("s1_hs_once", hs_q.size() - hb, 1);
        chk("s1_busy_end", busy, 0);
        chk("s1_overrun", overrun, 0);

        // Upper half
        rb = rx_q.size(); ab = addr_q.size(); hb = hs_q.size();
        pulse_wd(1'b0);
        wait_hs("s2", hb + 1, 20000);
        repeat (30) @(negedge clk);
        check_half("s2", rb, ab, 1);
        chk("s2_nbytes", rx_q.size() - rb, 513);

        // Random RAM and UART timing; second request queued during streaming
        busy_min = 1;
        busy_max = 4;
        for (int i = 0; i < 512; i++) mem[i] = 16'($urandom);
        do_reset();
        rb = rx_q.size(); ab = addr_q.size(); sb = start_q.size(); hb = hs_q.size();
        pulse_wd(1'b0);
        repeat (300) @(negedge clk);
        pulse_wd(1'b1);
        wait_hs("s3", hb + 2, 20000);
        repeat (30) @(negedge clk);
        check_half("s3a", rb, ab, 1);
        check_half("s3b", rb + 513, ab + 256, 0);
        chk("s3_gap", (start_q.size() > sb + 513 && hs_q.size() > hb) ?
            start_q[sb + 513] - hs_q[hb] : -1, 2);
        chk("s3_overrun", overrun, 0);

        // write_done in the very cycle the queue is consumed
        do_reset();
        rb = rx_q.size(); ab = addr_q.size(); hb = hs_q.size();
        @(negedge clk);
        wr_half = 1'b0; write_done = 1'b1;
        @(negedge clk);
        wr_half = 1'b1;
        @(negedge clk);
        write_done = 1'b0;
        wait_hs("s3c", hb + 2, 20000);
        repeat (30) @(negedge clk);
        check_half("s3c_a", rb, ab, 1);
        check_half("s3c_b", rb + 513, ab + 256, 0);
        chk("s3c_overrun", overrun, 0);

        // Three requests while busy: third one overruns
        do_reset();
        rb = rx_q.size(); ab = addr_q.size(); hb = hs_q.size();
        pulse_wd(1'b1);
        repeat (50) @(negedge clk);
        pulse_wd(1'b0);
        repeat (50) @(negedge clk);
        chk("s4_no_overrun_yet", overrun, 0);
        pulse_wd(1'b1);
        @(negedge clk);
        chk("s4_overrun_set", overrun, 1);
        wait_hs("s4", hb + 2, 20000);
        repeat (300) @(negedge clk);
        chk("s4_halves", hs_q.size() - hb, 2);
        chk("s4_nbytes", rx_q.size() - rb, 1026);
        check_half("s4a", rb, ab, 0);
        check_half("s4b", rb + 513, ab + 256, 1);
        chk("s4_overrun_sticky", overrun, 1);

        // Reset during the high byte of word 37, with a queued request and overrun
        do_reset();
        rb = rx_q.size();
        pulse_wd(1'b1);
        repeat (30) @(negedge clk);
        pulse_wd(1'b0);
        pulse_wd(1'b1);
        k = 0;
        while (!(tx_start && rx_q.size() - rb == 75) && k < 10000) begin
            @(negedge clk);
            k++;
        end
        chk("s5_reached_word37", 32'(k < 10000), 1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check_outputs_zero("s5");
        chk("s5_last_byte", (rx_q.size() > rb + 75) ? rx_q[rb + 75] : 8'hxx, mem[37][15:8]);
        sb = start_q.size(); hb = hs_q.size();
        repeat (300) @(negedge clk);
        chk("s5_no_start", start_q.size() - sb, 0);
        chk("s5_no_hs", hs_q.size() - hb, 0);
        chk("s5_idle", busy, 0);

        // UART busy for 50 cycles before the header
        do_reset();
        @(negedge clk);
        force_busy = 1'b1;
        rb = rx_q.size(); ab = addr_q.size(); sb = start_q.size(); hb = hs_q.size();
        pulse_wd(1'b1);
        repeat (50) @(negedge clk);
        chk("s6_stalled", start_q.size() - sb, 0);
        chk("s6_busy", busy, 1);
        force_busy = 1'b0;
        wait_hs("s6", hb + 1, 20000);
        repeat (30) @(negedge clk);
        check_half("s6", rb, ab, 0);
        chk("s6_nbytes", rx_q.size() - rb, 513);

        chk("start_while_busy", n_bad_start, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
